// File: rtl/pwm_pkg.sv
// Shared definitions for the pwm generator/capture pair: capture FSM encoding
// and the default counter width so both sides count with the same range.
package pwm_pkg;

  localparam int PWM_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered one-cycle
// rise/fall strobes; a pin transition shows up on rise/fall SYNC_STAGES+1 edges later.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev   <= s;
      rise   <= s & ~prev;
      fall   <= ~s & prev;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM signal in clk cycles and
// flags a stuck or missing input after MAX cycles without an edge.
//
// state   | meaning
// ST_IDLE | no reference rise yet (after reset or timeout); cnt held at 0
// ST_HIGH | input high since last rise; waiting for fall
// ST_LOW  | input low after fall; next rise closes the measurement
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             active,
  output logic             timeout,
  output logic             level
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  pwm_state_t       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hi_cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic             s;
  logic             rise;
  logic             fall;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in (pwm_in),
    .s        (s),
    .rise     (rise),
    .fall     (fall)
  );

  assign level   = s;
  assign cnt_inc = (cnt == MAX) ? cnt : cnt + ONE;

  // Edges are checked before saturation so an edge landing on cnt==MAX still measures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi_cnt    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      active    <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise) begin
            cnt   <= ONE;
            state <= ST_HIGH;
          end else begin
            cnt <= '0;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            hi_cnt <= cnt;
            cnt    <= cnt_inc;
            state  <= ST_LOW;
          end else if (cnt == MAX) begin
            timeout <= 1'b1;
            active  <= 1'b0;
            cnt     <= '0;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_LOW: begin
          if (rise) begin
            period    <= cnt;
            high_time <= hi_cnt;
            valid     <= 1'b1;
            active    <= 1'b1;
            cnt       <= ONE;
            state     <= ST_HIGH;
          end else if (cnt == MAX) begin
            timeout <= 1'b1;
            active  <= 1'b0;
            cnt     <= '0;
            state   <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: pin edges are logged by cycle and an
// edge-list model predicts every valid/timeout with its values and timing.
module tb_pwm_capture;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int MAXV = (1 << W) - 1;
  localparam int LAT  = S + 2;

  logic         clk;
  logic         rst;
  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         active;
  logic         timeout;
  logic         level;

  pwm_capture #(
    .WIDTH       (W),
    .SYNC_STAGES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .active    (active),
    .timeout   (timeout),
    .level     (level)
  );

  typedef struct {
    int c;
    int per;
    int hi;
    int at;
  } meas_t;

  meas_t vq[$];
  int    tq[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    tol = 0;
  int    last_per = 0;
  bit    armed = 0;
  bit    seen_fall = 0;
  int    last_rise = 0;
  int    last_fall = 0;
  longint base_t;
  int    base_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp, input int t = 0);
    longint d;
    n_checks++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > t) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, obs, exp, t, cyc);
    end
  endtask

  // Model: a valid for every rise that follows an armed rise and a fall; a
  // timeout whenever no edge arrives within MAXV cycles of the last rise.
  task automatic model_edge(input logic lvl, input int c);
    meas_t m;
    if (lvl) begin
      if (armed && seen_fall) begin
        m.c   = c;
        m.per = c - last_rise;
        m.hi  = last_fall - last_rise;
        m.at  = c + LAT;
        vq.push_back(m);
      end
      armed     = 1;
      last_rise = c;
      seen_fall = 0;
    end else if (armed) begin
      seen_fall = 1;
      last_fall = c;
    end
  endtask

  task automatic lookahead(input int next_c);
    if (armed && (next_c - last_rise) > MAXV) begin
      tq.push_back(last_rise + MAXV + LAT);
      armed = 0;
    end
  endtask

  task automatic seg(input logic lvl, input int len);
    if (lvl != pwm_in) model_edge(lvl, cyc);
    pwm_in = lvl;
    lookahead(cyc + len);
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic async_edge(input logic lvl, input int n);
    longint target;
    target = base_t + longint'(n) * 10 + longint'($urandom_range(0, 8)) - 4;
    if (target > $time) #(target - $time);
    model_edge(lvl, base_c + n);
    pwm_in = lvl;
  endtask

  task automatic pulses(input int hi, input int lo, input int reps);
    repeat (reps) begin
      seg(1'b1, hi);
      seg(1'b0, lo);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (vq.size() == 0) begin
          chk("valid_spurious", 1, 0);
        end else begin
          meas_t e;
          e = vq.pop_front();
          chk("period", period, e.per, tol);
          chk("high_time", high_time, e.hi, tol);
          chk("valid_latency", cyc - e.c, LAT, tol);
          chk("active_on_valid", active, 1);
          last_per = e.per;
        end
      end else if (vq.size() > 0 && cyc > vq[0].at + tol) begin
        chk("valid_missing", 0, 1);
        void'(vq.pop_front());
      end
      if (timeout) begin
        if (tq.size() == 0) begin
          chk("timeout_spurious", 1, 0);
        end else begin
          int at;
          at = tq.pop_front();
          chk("timeout_cycle", cyc, at, tol);
          chk("active_after_timeout", active, 0);
          chk("period_hold", period, last_per, tol);
          chk("level_stuck", level, pwm_in);
        end
      end else if (tq.size() > 0 && cyc > tq[0] + tol) begin
        chk("timeout_missing", 0, 1);
        void'(tq.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int h;
    int n;
    rst    = 1'b1;
    pwm_in = 1'b0;
    @(negedge clk);
    chk("rst_period", period, 0);
    chk("rst_high_time", high_time, 0);
    chk("rst_valid", valid, 0);
    chk("rst_active", active, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_level", level, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seg(1'b0, 5);

    pulses(5, 5, 8);
    pulses(2, 8, 4);
    repeat (30) begin
      p = $urandom_range(2, 40);
      h = $urandom_range(1, p - 1);
      pulses(h, p - h, $urandom_range(2, 5));
    end
    pulses(1, 1, 10);

    // Reset in the middle of a high phase discards the measurement.
    seg(1'b1, 36);
    #3;
    rst = 1'b1;
    #1;
    chk("amid_period", period, 0);
    chk("amid_high_time", high_time, 0);
    chk("amid_valid", valid, 0);
    chk("amid_active", active, 0);
    chk("amid_timeout", timeout, 0);
    chk("amid_level", level, 0);
    vq.delete();
    tq.delete();
    armed    = 0;
    last_per = 0;
    pwm_in   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seg(1'b0, 5);
    pulses(4, 6, 4);

    // Pin edges jittered off the clock grid; counts may move by one cycle.
    tol    = 1;
    base_t = $time;
    base_c = cyc;
    n      = 0;
    repeat (16) begin
      h = $urandom_range(3, 8);
      p = h + $urandom_range(3, 8);
      async_edge(1'b1, n);
      n += h;
      async_edge(1'b0, n);
      n += p - h;
    end
    @(posedge clk);
    #1;
    seg(1'b0, 300);
    tol = 0;

    pulses(5, 5, 2);
    seg(1'b1, 300);
    seg(1'b0, 20);

    pulses(10, 245, 2);
    pulses(10, 246, 1);
    pulses(10, 10, 2);

    seg(1'b0, 300);
    repeat (10) @(posedge clk);
    chk("valid_left", vq.size(), 0);
    chk("timeout_left", tq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an incoming PWM waveform, acting as the receive-side counterpart to the team's pwm generator. It reports the period and high time in clk cycles, one measurement per input period. It sits on a top-level input pin, for example in a loopback from a pwm output, and feeds LEDs or a debug/serial path. It also detects a stuck input (0% or 100% duty, or no signal).

Parameters:
WIDTH, 16, width of the period/high-time counters and outputs; MAX = 2^WIDTH-1
SYNC_STAGES, 2, number of synchronizer flops on pwm_in (minimum 2)

Ports:
clk  input  1  system clock (50 MHz on the board)
rst  input  1  asynchronous, active-high reset
pwm_in  input  1  asynchronous PWM input
period  output  WIDTH  clk cycles between the last two rising edges
high_time  output  WIDTH  clk cycles from the last rising edge to the following falling edge
valid  output  1  one-cycle pulse; period and high_time were just updated
active  output  1  level; high while a periodic signal is being measured
timeout  output  1  one-cycle pulse; no edge within MAX cycles
level  output  1  synchronized pwm_in; gives the stuck level after a timeout

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- On rst, every flop clears: state IDLE, counter 0, period 0, high_time 0, valid 0, active 0, timeout 0, level 0, sync chain 0.
- Synchronizer and edge detect:
  - pwm_in passes through SYNC_STAGES flops to give s; prev is s delayed one cycle.
  - rise = s & ~prev; fall = ~s & prev; level = s.
  - A pin transition is seen as rise/fall exactly SYNC_STAGES+1 clk edges later.
- Counter cnt (WIDTH bits):
  - Loaded with 1 on the cycle rise is seen; otherwise increments each cycle while in HIGH or LOW.
  - Saturates at MAX and never wraps.
- FSM states are IDLE, HIGH and LOW.
- IDLE:
  - rise: go to HIGH, cnt<=1; no valid is produced.
  - fall: ignored; cnt is held at 0.
- HIGH:
  - fall: hi_cnt<=cnt, go to LOW.
  - cnt==MAX with no fall: timeout pulse, active<=0, go to IDLE.
- LOW:
  - rise: period<=cnt, high_time<=hi_cnt, valid<=1, active<=1, cnt<=1, go to HIGH.
  - cnt==MAX with no rise: timeout pulse, active<=0, go to IDLE.
- Edge versus saturation in the same cycle: the edge wins. A rise with cnt==MAX reports period=MAX with valid and no timeout.
- Timing of outputs:
  - valid, period and high_time update on the clk edge after the cycle in which rise is seen.
  - period and high_time hold until the next valid or rst.
- Values and width rules:
  - For a rising-edge spacing of P cycles and high time H: period=P, high_time=H.
  - Invariant 1 <= high_time < period.
- Edge alternation: rise and fall cannot occur in the same cycle, and edges alternate by construction. No other transitions exist.
- Reset mid-measurement: the measurement is discarded. The first valid after release needs two rising edges.

Decomposition:
- Shared package pwm_pkg holds:
  - FSM state encodings (ST_IDLE=2'd0, ST_HIGH=2'd1, ST_LOW=2'd2).
  - The default WIDTH, shared with the pwm generator so counter widths match.
- One sub-module, sync_edge (parameter SYNC_STAGES):
  - Inputs clk, rst, async_in.
  - Outputs s, rise, fall.
  - Reusable for buttons and avr_tx.
- pwm_capture instantiates sync_edge and holds the FSM, counter and output registers.

Test Plan:
- Reset check: assert rst mid-stream while HIGH with cnt=37 -> all outputs 0 immediately (asynchronous), state IDLE. After release, first valid only after two rising edges.
- Steady PWM: period 10, high 5 clk -> first valid after the 2nd rise with period=10, high_time=5. Thereafter valid every 10 cycles, active=1. Check the latency of valid from the pin rise equals SYNC_STAGES+2.
- Duty change: switch from high 5 to high 2 at constant period 10 -> the next valid reports high_time=2, period=10. There are no spurious pulses.
- Stuck high (WIDTH=8): hold pwm_in=1 after a rise -> timeout pulses once, 255 cycles after the rise; active=0, level=1, and period/high_time keep their old values.
- Edge versus saturation (WIDTH=8): rising edges exactly 255 cycles apart -> valid with period=255 and no timeout. At 256 apart -> timeout, then IDLE, and the next rise produces no valid.
- Narrow pulses: period 2, high 1 -> valid every 2 cycles with period=2, high_time=1. Also run with asynchronous, non-clk-aligned pin edges and check the counts are within ±1.
